// File: rtl/cpu_bus_arb.sv
// cpu_bus_arb: two-requester round-robin arbiter driving the shared CPU
// configuration bus (Intel or Motorola strobe style) with a bounded wait
// for Rdy_Dtack and a held response register.

package cpu_bus_arb_pkg;
  // Lookup-table cell configuration word carried on the CPU bus.
  typedef struct packed {
    logic [3:0]  fwd;
    logic [15:0] vpi;
  } CellCfgType;
endpackage

// Shared CPU configuration bus; the Test side drives the transaction.
interface cpu_ifc;
  import cpu_bus_arb_pkg::*;
  logic        BusMode;
  logic [11:0] Addr;
  CellCfgType  DataIn;
  CellCfgType  DataOut;
  logic        Sel;
  logic        Rd_DS;
  logic        Wr_RW;
  logic        Rdy_Dtack;
  modport Test (output BusMode, Addr, DataIn, Sel, Rd_DS, Wr_RW,
                input  DataOut, Rdy_Dtack);
endinterface

module cpu_bus_arb
  import cpu_bus_arb_pkg::*;
#(
  parameter int BUS_MODE = 1,
  parameter int TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic        req0_write,
  input  logic        req1_write,
  input  logic [11:0] req0_addr,
  input  logic [11:0] req1_addr,
  input  CellCfgType  req0_wdata,
  input  CellCfgType  req1_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output CellCfgType  rsp_rdata,
  output logic        rsp_timeout,
  cpu_ifc.Test        cpu
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

  localparam bit         INTEL    = (BUS_MODE != 0);
  // Last STROBE cycle index before giving up on Rdy_Dtack.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        run;        // set on the first clock edge after reset release
  logic        last_id;    // requester granted most recently
  logic        cur_write;
  logic        cur_id;
  logic [7:0]  tmo_cnt;
  logic [11:0] bus_addr;
  CellCfgType  bus_din;
  logic        bus_sel;
  logic        bus_rd;
  logic        bus_wr;
  logic        grant_any;
  logic        grant_id;

  // Saturating 8-bit increment for the strobe wait counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign cpu.BusMode = INTEL;
  assign cpu.Addr    = bus_addr;
  assign cpu.DataIn  = bus_din;
  assign cpu.Sel     = bus_sel;
  assign cpu.Rd_DS   = bus_rd;
  assign cpu.Wr_RW   = bus_wr;

  // Round-robin pick: prefer the requester not granted last when both ask.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (run && (state == IDLE) && (req0_valid || req1_valid)) begin
      grant_any = 1'b1;
      grant_id  = (req0_valid && req1_valid) ? ~last_id : req1_valid;
    end
    req0_ready = grant_any && !grant_id;
    req1_ready = grant_any &&  grant_id;
  end

  // Transaction sequencer: bus phases, ack/timeout handling, response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      run         <= 1'b0;
      last_id     <= 1'b1;
      cur_write   <= 1'b0;
      cur_id      <= 1'b0;
      tmo_cnt     <= 8'd0;
      bus_addr    <= '0;
      bus_din     <= '0;
      bus_sel     <= 1'b1;
      bus_rd      <= 1'b1;
      bus_wr      <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      run       <= 1'b1;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            state     <= SETUP;
            last_id   <= grant_id;
            cur_id    <= grant_id;
            cur_write <= grant_id ? req1_write : req0_write;
            bus_addr  <= grant_id ? req1_addr : req0_addr;
            if (grant_id)
              bus_din <= req1_write ? req1_wdata : '0;
            else
              bus_din <= req0_write ? req0_wdata : '0;
            bus_sel   <= 1'b0;
          end
        end
        SETUP: begin
          state   <= STROBE;
          tmo_cnt <= 8'd0;
          bus_rd  <= INTEL ? cur_write : 1'b0;
          bus_wr  <= !cur_write;
        end
        STROBE: begin
          if (!cpu.Rdy_Dtack || (tmo_cnt >= TMO_LAST)) begin
            state       <= RECOVER;
            rsp_valid   <= 1'b1;
            rsp_id      <= cur_id;
            rsp_timeout <= cpu.Rdy_Dtack;
            rsp_rdata   <= (!cpu.Rdy_Dtack && !cur_write) ? cpu.DataOut : '0;
            bus_addr    <= '0;
            bus_din     <= '0;
            bus_sel     <= 1'b1;
            bus_rd      <= 1'b1;
            bus_wr      <= 1'b1;
          end else begin
            tmo_cnt <= sat_inc(tmo_cnt);
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_arb.sv
// Directed bench for cpu_bus_arb: an Intel and a Motorola instance share
// the same request and bus-response stimulus.
module tb_cpu_bus_arb;
  import cpu_bus_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0v, r1v, r0w, r1w, rdy;
  logic [11:0] r0a, r1a;
  CellCfgType  r0d, r1d, dout;
  logic        i_rdy0, i_rdy1, i_rv, i_rid, i_rto;
  logic        m_rdy0, m_rdy1, m_rv, m_rid, m_rto;
  CellCfgType  i_rdata, m_rdata;
  int          n_cmp = 0;
  int          n_err = 0;
  int          ng;
  logic        gid [4];
  int          gcyc [4];

  always #5 clk = ~clk;

  cpu_ifc bus_i ();
  cpu_ifc bus_m ();
  assign bus_i.Rdy_Dtack = rdy;
  assign bus_i.DataOut   = dout;
  assign bus_m.Rdy_Dtack = rdy;
  assign bus_m.DataOut   = dout;

  cpu_bus_arb #(.BUS_MODE(1), .TIMEOUT(4)) dut_i (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req1_valid(r1v), .req0_ready(i_rdy0), .req1_ready(i_rdy1),
    .req0_write(r0w), .req1_write(r1w), .req0_addr(r0a), .req1_addr(r1a),
    .req0_wdata(r0d), .req1_wdata(r1d),
    .rsp_valid(i_rv), .rsp_id(i_rid), .rsp_rdata(i_rdata), .rsp_timeout(i_rto),
    .cpu(bus_i));

  cpu_bus_arb #(.BUS_MODE(0), .TIMEOUT(4)) dut_m (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req1_valid(r1v), .req0_ready(m_rdy0), .req1_ready(m_rdy1),
    .req0_write(r0w), .req1_write(r1w), .req0_addr(r0a), .req1_addr(r1a),
    .req0_wdata(r0d), .req1_wdata(r1d),
    .rsp_valid(m_rv), .rsp_id(m_rid), .rsp_rdata(m_rdata), .rsp_timeout(m_rto),
    .cpu(bus_m));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge (input drive point).
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b1;
    r0v = 1'b1; r1v = 1'b0; r0w = 1'b1; r1w = 1'b0;
    r0a = 12'h005; r1a = 12'h123;
    r0d = 20'hA00AB; r1d = 20'h00000;
    rdy = 1'b1; dout = 20'h00000;
    #1 rst_n = 1'b0;
    #2;
    // Reset state, asynchronous, with a request already pending
    chk("rst_ready0",  32'(i_rdy0), 32'd0);
    chk("rst_rsp_vld", 32'(i_rv), 32'd0);
    chk("rst_sel",     32'(bus_i.Sel), 32'd1);
    chk("rst_rd",      32'(bus_i.Rd_DS), 32'd1);
    chk("rst_wr",      32'(bus_i.Wr_RW), 32'd1);
    chk("rst_addr",    32'(bus_i.Addr), 32'd0);
    chk("rst_rdata",   32'(i_rdata), 32'd0);
    chk("busmode_i",   32'(bus_i.BusMode), 32'd1);
    chk("busmode_m",   32'(bus_m.BusMode), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    chk("rst_hold_ready0", 32'(i_rdy0), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("no_grant_before_edge", 32'(i_rdy0), 32'd0);

    // Intel write from req0, ack on first STROBE cycle
    nxt(); #1;
    chk("w_T_ready0", 32'(i_rdy0), 32'd1);
    chk("w_T_ready1", 32'(i_rdy1), 32'd0);
    nxt(); r0v = 1'b0; #1;
    chk("w_setup_sel",  32'(bus_i.Sel), 32'd0);
    chk("w_setup_wr",   32'(bus_i.Wr_RW), 32'd1);
    chk("w_setup_addr", 32'(bus_i.Addr), 32'h005);
    chk("w_setup_din",  32'(bus_i.DataIn), 32'hA00AB);
    nxt(); rdy = 1'b0; #1;
    chk("w_strobe_wr_i", 32'(bus_i.Wr_RW), 32'd0);
    chk("w_strobe_rd_i", 32'(bus_i.Rd_DS), 32'd1);
    chk("w_strobe_addr", 32'(bus_i.Addr), 32'h005);
    chk("w_strobe_rd_m", 32'(bus_m.Rd_DS), 32'd0);
    chk("w_strobe_wr_m", 32'(bus_m.Wr_RW), 32'd0);
    nxt(); rdy = 1'b1; #1;
    chk("w_rsp_vld",  32'(i_rv), 32'd1);
    chk("w_rsp_id",   32'(i_rid), 32'd0);
    chk("w_rsp_tmo",  32'(i_rto), 32'd0);
    chk("w_rsp_data", 32'(i_rdata), 32'd0);
    chk("w_rec_sel",  32'(bus_i.Sel), 32'd1);
    chk("w_rec_addr", 32'(bus_i.Addr), 32'd0);
    nxt(); #1;
    chk("w_rsp_pulse_end", 32'(i_rv), 32'd0);

    // Read from req1, ack on third STROBE cycle
    nxt(); r1v = 1'b1; r1w = 1'b0; r1a = 12'h123; #1;
    chk("r_T_ready1_m", 32'(m_rdy1), 32'd1);
    nxt(); r1v = 1'b0; #1;
    chk("r_setup_din",  32'(bus_m.DataIn), 32'd0);
    chk("r_setup_addr", 32'(bus_m.Addr), 32'h123);
    nxt(); #1;
    chk("r_strobe_rd_m", 32'(bus_m.Rd_DS), 32'd0);
    chk("r_strobe_wr_m", 32'(bus_m.Wr_RW), 32'd1);
    chk("r_strobe_rd_i", 32'(bus_i.Rd_DS), 32'd0);
    chk("r_strobe_wr_i", 32'(bus_i.Wr_RW), 32'd1);
    nxt(); #1;
    chk("r_strobe2_rd_m", 32'(bus_m.Rd_DS), 32'd0);
    chk("r_strobe2_vld",  32'(m_rv), 32'd0);
    nxt(); rdy = 1'b0; dout = 20'h0F123; #1;
    chk("r_strobe3_rd_m", 32'(bus_m.Rd_DS), 32'd0);
    nxt(); rdy = 1'b1; dout = 20'h0BEEF; #1;
    chk("r_rsp_vld",  32'(m_rv), 32'd1);
    chk("r_rsp_id",   32'(m_rid), 32'd1);
    chk("r_rsp_data", 32'(m_rdata), 32'h0F123);
    chk("r_rsp_tmo",  32'(m_rto), 32'd0);
    nxt(); #1;
    chk("r_rsp_hold_data", 32'(m_rdata), 32'h0F123);
    chk("r_rsp_hold_id",   32'(m_rid), 32'd1);
    chk("r_rsp_vld_end",   32'(m_rv), 32'd0);

    // Contention: both requesters held valid, immediate acks
    ng = 0;
    for (int i = 0; i < 16; i++) begin
      nxt();
      if (i == 0) begin
        r0v = 1'b1; r1v = 1'b1; r0w = 1'b0; r1w = 1'b0;
        rdy = 1'b0; dout = 20'h5A5A5;
      end
      #1;
      chk("cont_no_overlap", 32'(i_rdy0 & i_rdy1), 32'd0);
      if ((i_rdy0 || i_rdy1) && ng < 4) begin
        gid[ng]  = i_rdy1;
        gcyc[ng] = i;
        ng++;
      end
    end
    nxt(); r0v = 1'b0; r1v = 1'b0; rdy = 1'b1; #1;
    chk("cont_grants", 32'(ng), 32'd4);
    chk("cont_g0_id", 32'(gid[0]), 32'd0);
    chk("cont_g1_id", 32'(gid[1]), 32'd1);
    chk("cont_g2_id", 32'(gid[2]), 32'd0);
    chk("cont_g3_id", 32'(gid[3]), 32'd1);
    chk("cont_g1_cyc", 32'(gcyc[1]), 32'd4);
    chk("cont_g3_cyc", 32'(gcyc[3]), 32'd12);
    chk("cont_last_data", 32'(i_rdata), 32'h5A5A5);

    // Timeout: no ack for TIMEOUT=4 STROBE cycles
    nxt(); r0v = 1'b1; r0w = 1'b0; r0a = 12'h0AA; #1;
    chk("t_T_ready0", 32'(i_rdy0), 32'd1);
    nxt(); r0v = 1'b0; #1;
    chk("t_setup_sel", 32'(bus_i.Sel), 32'd0);
    for (int k = 0; k < 4; k++) begin
      nxt(); #1;
      chk("t_strobe_rd", 32'(bus_i.Rd_DS), 32'd0);
      chk("t_strobe_vld", 32'(i_rv), 32'd0);
    end
    nxt(); #1;
    chk("t_rsp_vld",   32'(i_rv), 32'd1);
    chk("t_rsp_tmo",   32'(i_rto), 32'd1);
    chk("t_rsp_data",  32'(i_rdata), 32'd0);
    chk("t_rsp_id",    32'(i_rid), 32'd0);
    chk("t_idle_sel",  32'(bus_i.Sel), 32'd1);
    chk("t_idle_rd",   32'(bus_i.Rd_DS), 32'd1);
    chk("t_idle_wr",   32'(bus_i.Wr_RW), 32'd1);
    chk("t_idle_addr", 32'(bus_i.Addr), 32'd0);
    chk("t_rsp_tmo_m", 32'(m_rto), 32'd1);
    nxt(); #1;
    chk("t_vld_end",  32'(i_rv), 32'd0);
    chk("t_tmo_hold", 32'(i_rto), 32'd1);

    // Lone req0 while pointer prefers req1; reset on second STROBE cycle
    nxt(); r0v = 1'b1; r0w = 1'b1; r0a = 12'h3C3; r0d = 20'h51234; #1;
    chk("x_T_ready0", 32'(i_rdy0), 32'd1);
    chk("x_T_ready1", 32'(i_rdy1), 32'd0);
    nxt(); r0v = 1'b0; #1;
    nxt(); #1;
    chk("x_strobe1_wr", 32'(bus_i.Wr_RW), 32'd0);
    chk("x_strobe1_sel", 32'(bus_i.Sel), 32'd0);
    nxt(); rst_n = 1'b0; #1;
    chk("x_rst_sel",  32'(bus_i.Sel), 32'd1);
    chk("x_rst_wr",   32'(bus_i.Wr_RW), 32'd1);
    chk("x_rst_rd",   32'(bus_i.Rd_DS), 32'd1);
    chk("x_rst_rd_m", 32'(bus_m.Rd_DS), 32'd1);
    chk("x_rst_addr", 32'(bus_i.Addr), 32'd0);
    chk("x_rst_vld",  32'(i_rv), 32'd0);
    chk("x_rst_tmo",  32'(i_rto), 32'd0);
    nxt(); r1v = 1'b1; r1w = 1'b0; r1a = 12'h7E7; #1;
    chk("x_rst_vld2",   32'(i_rv), 32'd0);
    chk("x_rst_ready1", 32'(i_rdy1), 32'd0);
    rst_n = 1'b1; #1;
    chk("x_rel_ready1", 32'(i_rdy1), 32'd0);
    nxt(); #1;
    chk("x_post_ready1", 32'(i_rdy1), 32'd1);
    chk("x_post_ready0", 32'(i_rdy0), 32'd0);
    nxt(); r1v = 1'b0; rdy = 1'b0; dout = 20'h12345; #1;
    chk("x_setup_sel",  32'(bus_i.Sel), 32'd0);
    chk("x_setup_addr", 32'(bus_i.Addr), 32'h7E7);
    nxt(); #1;
    chk("x_strobe_rd", 32'(bus_i.Rd_DS), 32'd0);
    nxt(); rdy = 1'b1; #1;
    chk("x_rsp_vld",  32'(i_rv), 32'd1);
    chk("x_rsp_id",   32'(i_rid), 32'd1);
    chk("x_rsp_data", 32'(i_rdata), 32'h12345);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
